// File: rtl/decode_if.sv
// Fetch/execute-facing signals of the decode stage.
// The slave modport is the decode stage; master is whatever sits around it.
interface decode_if;
  logic [31:0] pc_in;
  logic [31:0] insn_in;
  logic        insn_valid;
  logic        stall_in;
  logic        flush;
  logic [31:0] pc_out;
  logic [31:0] insn_out;
  logic        valid_out;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [31:0] jump_target;
  logic [4:0]  dest_reg;
  logic        is_load;
  logic        illegal;
  logic        stall_out;
  logic        overflow;

  modport slave (
    input  pc_in, insn_in, insn_valid, stall_in, flush,
    output pc_out, insn_out, valid_out, opcode, rs, rt, rd, shamt, funct,
           imm_ext, jump_target, dest_reg, is_load, illegal, stall_out, overflow
  );

  modport master (
    output pc_in, insn_in, insn_valid, stall_in, flush,
    input  pc_out, insn_out, valid_out, opcode, rs, rt, rd, shamt, funct,
           imm_ext, jump_target, dest_reg, is_load, illegal, stall_out, overflow
  );
endinterface

// File: rtl/decode.sv
// MIPS-I decode stage: field split, load-use bubble insertion and a small
// skid FIFO that absorbs beats fetch sent before it saw stall_out.
module decode #(
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSN  = 32'h00000000
) (
  input logic     clock,
  input logic     reset_n,
  decode_if.slave bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc_buf   [BUF_DEPTH];
  logic [31:0]   insn_buf [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after_pop, count_nxt;

  logic        fifo_empty, src_valid, reads_rt, hazard, adv, pop, push, push_ok;
  logic [31:0] src_pc, src_insn, pc_plus4;
  logic [5:0]  s_op;
  logic [31:0] d_imm, d_jt;
  logic [4:0]  d_dest;
  logic        d_is_load, d_illegal;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    fifo_empty = (count == '0);
    src_pc     = fifo_empty ? bus.pc_in   : pc_buf[rd_ptr];
    src_insn   = fifo_empty ? bus.insn_in : insn_buf[rd_ptr];
    src_valid  = !fifo_empty || bus.insn_valid;
    s_op       = src_insn[31:26];
    reads_rt   = s_op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};

    // The held load's rt is still in the output register while we look at src.
    hazard = bus.valid_out && bus.is_load && (bus.rt != 5'd0) && src_valid &&
             ((bus.rt == src_insn[25:21]) || (reads_rt && (bus.rt == src_insn[20:16])));
    adv    = src_valid && !bus.stall_in && !hazard;

    pop             = adv && !fifo_empty;
    push            = bus.insn_valid && !(fifo_empty && adv);
    count_after_pop = count - CW'(pop);
    push_ok         = push && (count_after_pop != CW'(BUF_DEPTH));
    count_nxt       = count_after_pop + CW'(push_ok);
  end

  always_comb begin
    pc_plus4  = src_pc + 32'd4;
    d_jt      = {pc_plus4[31:28], src_insn[25:0], 2'b00};
    d_imm     = {{16{src_insn[15]}}, src_insn[15:0]};
    if (s_op inside {6'h0C, 6'h0D, 6'h0E})
      d_imm = {16'h0000, src_insn[15:0]};
    d_is_load = s_op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    d_illegal = !((s_op <= 6'h0F) || d_is_load || (s_op inside {6'h28, 6'h29, 6'h2B}));
    d_dest    = 5'd0;
    if (s_op == 6'h00)
      d_dest = (src_insn[5:0] == 6'h08) ? 5'd0 : src_insn[15:11];
    else if (s_op == 6'h03)
      d_dest = 5'd31;
    else if ((s_op >= 6'h08 && s_op <= 6'h0F) || d_is_load)
      d_dest = src_insn[20:16];
  end

  always_ff @(posedge clock) begin
    if (!reset_n || bus.flush || (!bus.stall_in && !adv)) begin
      bus.valid_out   <= 1'b0;
      bus.pc_out      <= '0;
      bus.insn_out    <= NOP_INSN;
      bus.opcode      <= '0;
      bus.rs          <= '0;
      bus.rt          <= '0;
      bus.rd          <= '0;
      bus.shamt       <= '0;
      bus.funct       <= '0;
      bus.imm_ext     <= '0;
      bus.jump_target <= '0;
      bus.dest_reg    <= '0;
      bus.is_load     <= 1'b0;
      bus.illegal     <= 1'b0;
    end else if (!bus.stall_in) begin
      bus.valid_out   <= 1'b1;
      bus.pc_out      <= src_pc;
      bus.insn_out    <= src_insn;
      bus.opcode      <= src_insn[31:26];
      bus.rs          <= src_insn[25:21];
      bus.rt          <= src_insn[20:16];
      bus.rd          <= src_insn[15:11];
      bus.shamt       <= src_insn[10:6];
      bus.funct       <= src_insn[5:0];
      bus.imm_ext     <= d_imm;
      bus.jump_target <= d_jt;
      bus.dest_reg    <= d_dest;
      bus.is_load     <= d_is_load;
      bus.illegal     <= d_illegal;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || bus.flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.stall_out <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      count         <= count_nxt;
      bus.stall_out <= (count_nxt != '0);
    end
  end

  // Overflow survives a flush; only reset clears it.
  always_ff @(posedge clock) begin
    if (!reset_n)
      bus.overflow <= 1'b0;
    else if (!bus.flush && push && !push_ok)
      bus.overflow <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset_n && !bus.flush && push_ok) begin
      pc_buf[wr_ptr]   <= bus.pc_in;
      insn_buf[wr_ptr] <= bus.insn_in;
    end
  end
endmodule

// File: tb/tb_decode.sv
// Directed and randomized checks of the decode stage against a queue-based
// reference model of the pipeline register and skid buffer.
module tb_decode;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  decode_if bus();

  decode #(.BUF_DEPTH(DEPTH), .NOP_INSN(32'h00000000)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } beat_t;

  beat_t       q[$];
  bit          m_valid, m_ovf, m_stall;
  logic [31:0] m_pc, m_insn;

  function automatic int op_of(input logic [31:0] i);
    return int'(i >> 26);
  endfunction

  function automatic bit is_load_op(input int op);
    return op == 32 || op == 33 || op == 35 || op == 36 || op == 37;
  endfunction

  function automatic bit reads_rt_op(input int op);
    return op == 0 || op == 4 || op == 5 || op == 40 || op == 41 || op == 43;
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    int op = op_of(i);
    if (op == 12 || op == 13 || op == 14) return i & 32'hFFFF;
    return 32'($signed(i[15:0]));
  endfunction

  function automatic logic [31:0] exp_jt(input logic [31:0] pc, input logic [31:0] i);
    logic [31:0] nxt = pc + 32'd4;
    return (nxt & 32'hF0000000) | ((i & 32'h03FFFFFF) * 4);
  endfunction

  function automatic logic [31:0] exp_dest(input logic [31:0] i);
    int op = op_of(i);
    if (op == 0) return ((i & 63) == 8) ? 0 : (i >> 11) & 31;
    if (op == 3) return 31;
    if ((op >= 8 && op <= 15) || is_load_op(op)) return (i >> 16) & 31;
    return 0;
  endfunction

  function automatic bit exp_illegal(input logic [31:0] i);
    int op = op_of(i);
    return !(op <= 15 || is_load_op(op) || op == 40 || op == 41 || op == 43);
  endfunction

  task automatic model_step();
    bit    sv, haz, adv, was_empty;
    beat_t s;
    int    m_rt;
    sv = 0;
    s.pc = '0;
    s.insn = '0;
    if (!reset_n) begin
      q.delete();
      m_valid = 0; m_pc = '0; m_insn = '0; m_ovf = 0; m_stall = 0;
    end else if (bus.flush) begin
      q.delete();
      m_valid = 0; m_pc = '0; m_insn = '0; m_stall = 0;
    end else begin
      if (q.size() > 0) begin
        s = q[0]; sv = 1;
      end else if (bus.insn_valid) begin
        s.pc = bus.pc_in; s.insn = bus.insn_in; sv = 1;
      end
      m_rt = int'((m_insn >> 16) & 31);
      haz = m_valid && is_load_op(op_of(m_insn)) && m_rt != 0 && sv &&
            (m_rt == int'((s.insn >> 21) & 31) ||
             (reads_rt_op(op_of(s.insn)) && m_rt == int'((s.insn >> 16) & 31)));
      adv = sv && !bus.stall_in && !haz;
      was_empty = (q.size() == 0);
      if (!bus.stall_in) begin
        m_valid = adv;
        m_pc    = adv ? s.pc : 32'h0;
        m_insn  = adv ? s.insn : 32'h0;
      end
      if (adv && !was_empty) void'(q.pop_front());
      if (bus.insn_valid && !(was_empty && adv)) begin
        if (q.size() < DEPTH) q.push_back('{bus.pc_in, bus.insn_in});
        else m_ovf = 1;
      end
      m_stall = (q.size() != 0);
    end
  endtask

  task automatic check_all();
    logic [31:0] ei;
    ei = m_valid ? m_insn : 32'h0;
    chk("valid_out",   bus.valid_out,   m_valid);
    chk("pc_out",      bus.pc_out,      m_valid ? m_pc : 32'h0);
    chk("insn_out",    bus.insn_out,    ei);
    chk("opcode",      bus.opcode,      ei >> 26);
    chk("rs",          bus.rs,          (ei >> 21) & 31);
    chk("rt",          bus.rt,          (ei >> 16) & 31);
    chk("rd",          bus.rd,          (ei >> 11) & 31);
    chk("shamt",       bus.shamt,       (ei >> 6) & 31);
    chk("funct",       bus.funct,       ei & 63);
    chk("imm_ext",     bus.imm_ext,     m_valid ? exp_imm(ei) : 32'h0);
    chk("jump_target", bus.jump_target, m_valid ? exp_jt(m_pc, ei) : 32'h0);
    chk("dest_reg",    bus.dest_reg,    m_valid ? exp_dest(ei) : 32'h0);
    chk("is_load",     bus.is_load,     m_valid && is_load_op(op_of(ei)));
    chk("illegal",     bus.illegal,     m_valid && exp_illegal(ei));
    chk("stall_out",   bus.stall_out,   m_stall);
    chk("overflow",    bus.overflow,    m_ovf);
  endtask

  task automatic step(input bit rn, input bit v, input logic [31:0] pc, input logic [31:0] insn,
                      input bit st, input bit fl);
    reset_n        = rn;
    bus.insn_valid = v;
    bus.pc_in      = pc;
    bus.insn_in    = insn;
    bus.stall_in   = st;
    bus.flush      = fl;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  function automatic logic [31:0] rand_insn();
    int          ops[20] = '{0, 2, 3, 4, 5, 8, 12, 13, 14, 15, 32, 33, 35, 36, 37, 40, 41, 43, 63, 1};
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] lo;
    op = 6'(ops[$urandom_range(0, 19)]);
    rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    lo = 16'($urandom);
    return {op, rs, rt, lo};
  endfunction

  initial begin
    logic [31:0] pc;
    reset_n = 1'b0;
    bus.insn_valid = 1'b0; bus.pc_in = '0; bus.insn_in = '0;
    bus.stall_in = 1'b0; bus.flush = 1'b0;

    // Reset with a valid beat presented; it must be ignored.
    step(0, 1, 32'h1000, 32'h8C430004, 0, 0);
    step(0, 1, 32'h1004, 32'h8C430004, 0, 0);
    chk("rst_stall", bus.stall_out, 1'b0);

    // Direct decode of lw $3,4($2).
    step(1, 1, 32'h80020000, 32'h8C430004, 0, 0);
    chk("dir_valid", bus.valid_out, 1'b1);
    chk("dir_imm",   bus.imm_ext,   32'h00000004);
    chk("dir_dest",  bus.dest_reg,  32'd3);

    // Load-use: add $4,$3,$5 right behind the load.
    step(1, 1, 32'h80020004, 32'h00652020, 0, 0);
    chk("lu_bubble", bus.valid_out, 1'b0);
    chk("lu_stall",  bus.stall_out, 1'b1);
    step(1, 0, 32'h0, 32'h0, 0, 0);
    chk("lu_dest",  bus.dest_reg,  32'd4);
    chk("lu_funct", bus.funct,     32'h20);
    chk("lu_stall_clr", bus.stall_out, 1'b0);

    // Backpressure fills the FIFO, third beat overflows, flush under stall.
    step(1, 1, 32'h200, 32'h20010001, 1, 0);
    step(1, 1, 32'h204, 32'h20020002, 1, 0);
    step(1, 0, 32'h0,   32'h0,        1, 0);
    step(1, 0, 32'h0,   32'h0,        1, 0);
    chk("bp_ovf0", bus.overflow, 1'b0);
    step(1, 1, 32'h208, 32'h20030003, 1, 0);
    chk("bp_ovf1", bus.overflow, 1'b1);
    step(1, 0, 32'h0, 32'h0, 1, 1);
    chk("fl_valid", bus.valid_out, 1'b0);
    chk("fl_stall", bus.stall_out, 1'b0);
    chk("fl_ovf",   bus.overflow,  1'b1);
    step(1, 1, 32'h300, 32'h20040004, 0, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0);

    // Extension, jump target and illegal opcode.
    step(0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 1, 32'h400, 32'h2001FFFF, 0, 0);
    chk("addi_imm", bus.imm_ext, 32'hFFFFFFFF);
    step(1, 1, 32'h404, 32'h3401FFFF, 0, 0);
    chk("ori_imm", bus.imm_ext, 32'h0000FFFF);
    step(1, 1, 32'h80020000, 32'h08000010, 0, 0);
    chk("j_target", bus.jump_target, 32'h80000040);
    chk("j_dest",   bus.dest_reg,    32'd0);
    step(1, 1, 32'hFFFFFFFC, 32'h08000010, 0, 0);
    chk("j_wrap", bus.jump_target, 32'h00000040);
    step(1, 1, 32'h408, 32'hFC000000, 0, 0);
    chk("illegal_3f", bus.illegal, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      pc = ($urandom_range(0, 49) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 6),
           pc, rand_insn(),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 32) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction-decode stage that sits directly downstream of the fetch stage and instruction memory.
- Accepts a fetched MIPS-I instruction word with its PC and splits it into register fields and immediates.
- Detects load-use hazards against the instruction it already holds, and inserts bubbles when one is found.
- Buffers in-flight instructions in a small skid FIFO and asserts stall_out back to fetch.

Parameters:
BUF_DEPTH, 2, skid FIFO entries (pc+insn pairs); must be >=2 to cover fetch/memory round-trip
NOP_INSN, 32'h00000000, value driven on insn_out during bubbles/reset

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
pc_in  input  32  PC of instruction on insn_in
insn_in  input  32  instruction word from memory
insn_valid  input  1  insn_in/pc_in valid this cycle
stall_in  input  1  downstream (execute) not accepting; hold outputs
flush  input  1  kill held and buffered instructions (branch redirect)
pc_out  output  32  registered PC of decoded instruction
insn_out  output  32  registered raw instruction
valid_out  output  1  decoded outputs valid
opcode  output  6  insn[31:26]
rs  output  5  insn[25:21]
rt  output  5  insn[20:16]
rd  output  5  insn[15:11]
shamt  output  5  insn[10:6]
funct  output  6  insn[5:0]
imm_ext  output  32  extended insn[15:0]
jump_target  output  32  {pc+4[31:28], insn[25:0], 2'b00}
dest_reg  output  5  register written (0 = none)
is_load  output  1  opcode in {0x20,0x21,0x23,0x24,0x25}
illegal  output  1  unsupported opcode
stall_out  output  1  to fetch stall; registered
overflow  output  1  sticky: instruction dropped because FIFO full

Behaviour:
- Synchronous active-low reset, one clock. All outputs are registered.
- Reset (reset_n=0 at posedge): all outputs 0, insn_out=NOP_INSN, FIFO emptied, overflow cleared. Has priority over flush/stall_in. Inputs during reset are ignored.
- Source selection: src = FIFO head if non-empty, else {pc_in, insn_in, insn_valid}.
- Hazard (combinational) condition, all of the following must hold:
  - valid_out=1 and is_load=1 and rt(out)!=0;
  - src valid;
  - rt(out)==src.rs, or (src reads rt and rt(out)==src.rt).
- "Reads rt" means opcode 0x00, 0x04, 0x05, 0x28, 0x29 or 0x2B.
- adv = src valid & !stall_in & !hazard.
- Per-posedge priority: reset > flush > normal.
- Flush:
  - valid_out<=0, decoded fields<=0, insn_out<=NOP_INSN, FIFO emptied.
  - Same-cycle insn_valid beat is dropped and does not set overflow.
  - stall_out<=0; overflow unchanged.
  - Flush acts even while stall_in=1.
- Normal, output register:
  - stall_in=1: hold every output.
  - else adv: load decoded src, valid_out<=1.
  - else: bubble (valid_out<=0, fields 0, NOP).
- Normal, FIFO:
  - Pop head when adv and head was src.
  - Push incoming beat when insn_valid and not consumed directly. Direct consumption happens only when FIFO is empty and adv.
  - Simultaneous pop+push is allowed.
  - Push with FIFO full after pop: beat dropped, overflow<=1 (sticky until reset).
- stall_out <= (next FIFO count != 0).
- Latency: insn_valid to valid_out is 1 cycle on the direct path; +1 cycle per buffered entry ahead.
- Load-use: exactly one bubble cycle per hazard; dependent instruction issues the following cycle (hazard clears once the bubble replaces the load).
- imm_ext:
  - zero-extend for opcodes 0x0C, 0x0D, 0x0E;
  - all others sign-extend bit 15.
- jump_target uses pc+4 with 32-bit wrap (pc 0xFFFFFFFC -> upper nibble 0).
- dest_reg:
  - opcode 0x00 -> rd, except funct 0x08 (JR) -> 0;
  - 0x03 (JAL) -> 31;
  - 0x08–0x0F and loads -> rt;
  - all others (stores, branches, J, 0x01) -> 0.
- illegal=1 unless opcode is in {0x00–0x0F, 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B}. The instruction still issues with valid_out=1.

Test Plan:
- Reset: reset_n=0 two cycles with insn_valid=1 -> all outputs 0, stall_out=0. First beat after release appears with valid_out=1 one cycle later.
- Direct decode: pc_in=0x80020000, insn_in=0x8C430004 -> next cycle valid_out=1, opcode=0x23, rs=2, rt=3, imm_ext=0x00000004, dest_reg=3, is_load=1, pc_out=0x80020000.
- Load-use: 0x8C430004 then 0x00652020 on consecutive cycles -> add is buffered, one bubble (valid_out=0), stall_out=1 for 1 cycle. Add issues next cycle with rd=4, funct=0x20, dest_reg=4.
- Backpressure/overflow:
  - stall_in=1 for 4 cycles with 2 valid beats -> outputs held, both buffered in order, stall_out=1, overflow=0.
  - A 3rd beat while full -> overflow=1 and that beat is never issued.
- Flush: FIFO full and stall_in=1, pulse flush -> next cycle valid_out=0, stall_out=0; later beats decode normally; overflow unchanged.
- Extension/jump:
  - addi imm 0xFFFF -> imm_ext=0xFFFFFFFF.
  - ori imm 0xFFFF -> 0x0000FFFF.
  - 0x08000010 at pc 0x80020000 -> jump_target=0x80000040, dest_reg=0.
  - Opcode 0x3F -> illegal=1.
